if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter and drives the byte address into the instruction memory. Captures the returned 32-bit word into the IF/ID pipeline register.
- Obeys freeze requests from the hazard detection unit and branch/jump redirects from the ID stage.
- Also keeps fetch and stall performance counters.

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage_if.sv | 30 +++
 rtl/if_stage_if_id_reg.sv | 36 +++
 rtl/if_stage.sv | 122 ++++++++++++
 tb/tb_if_stage.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch-path definitions: datapath width, NOP encoding, PC step, fetch FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package if_stage_pkg;

    localparam int WORD_LEN = 32;
    localparam int CNT_LEN  = 32;
    localparam int PC_STEP  = 4;

    // An all-zero word decodes as SLL $0,$0,0, which is the canonical MIPS NOP.
    localparam logic [WORD_LEN-1:0] NOP_INSTR = '0;

    // BOOT is a one-edge settling state after reset; RUN is permanent until reset.
    typedef enum logic {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: hazard/redirect controls, instruction memory port, IF/ID outputs, counters.
// Latency: n/a (wiring only).
// Backpressure: freeze is the only stall; there is no ready signal on the memory side.
interface if_stage_if #(
    parameter int WORD_LEN = if_stage_pkg::WORD_LEN,
    parameter int CNT_LEN  = if_stage_pkg::CNT_LEN
);
    logic                freeze;
    logic                branch_taken;
    logic [WORD_LEN-1:0] branch_addr;
    logic [WORD_LEN-1:0] imem_addr;
    logic [WORD_LEN-1:0] imem_instr;
    logic [WORD_LEN-1:0] if_id_pc;
    logic [WORD_LEN-1:0] if_id_instr;
    logic                if_id_valid;
    logic [CNT_LEN-1:0]  fetch_count;
    logic [CNT_LEN-1:0]  stall_count;

    // Fetch-stage side.
    modport master (
        input  freeze, branch_taken, branch_addr, imem_instr,
        output imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count, stall_count
    );

    // Surrounding pipeline / memory side.
    modport slave (
        output freeze, branch_taken, branch_addr, imem_instr,
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count, stall_count
    );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with stall (hold) and squash (flush) controls; flush wins over hold.
// Latency: 1 cycle from d_* to q_*.
// Backpressure: hold freezes contents; flush inserts a bubble (pc=0, NOP, valid=0).
module if_id_reg #(
    parameter int W = if_stage_pkg::WORD_LEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         flush,
    input  logic [W-1:0] d_pc,
    input  logic [W-1:0] d_instr,
    output logic [W-1:0] q_pc,
    output logic [W-1:0] q_instr,
    output logic         q_valid
);
    import if_stage_pkg::*;

    // Capture, hold or squash the fetched word; a squash must beat a stall so redirects are never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_pc    <= '0;
            q_instr <= W'(NOP_INSTR);
            q_valid <= 1'b0;
        end else if (flush) begin
            q_pc    <= '0;
            q_instr <= W'(NOP_INSTR);
            q_valid <= 1'b0;
        end else if (!hold) begin
            q_pc    <= d_pc;
            q_instr <= d_instr;
            q_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, BOOT/RUN sequencing, IF/ID register, fetch/stall counters.
// Latency: 1 cycle from imem_addr to if_id_instr; imem_addr is the registered PC.
// Backpressure: freeze holds PC and IF/ID; branch_taken overrides freeze and flushes IF/ID.
module if_stage #(
    parameter int                  WORD_LEN = if_stage_pkg::WORD_LEN,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0,
    parameter int                  CNT_LEN  = if_stage_pkg::CNT_LEN
) (
    input  logic      clk,
    input  logic      rst,
    if_stage_if.master bus
);
    import if_stage_pkg::*;

    fetch_state_t        state_q;
    fetch_state_t        state_d;
    logic [WORD_LEN-1:0] pc_q;
    logic [WORD_LEN-1:0] pc_d;
    logic [WORD_LEN-1:0] pc_plus4;
    logic [WORD_LEN-1:0] redirect_pc;
    logic                ifid_hold;
    logic                ifid_flush;
    logic                fetch_inc;
    logic                stall_inc;
    logic [CNT_LEN-1:0]  fetch_cnt_q;
    logic [CNT_LEN-1:0]  stall_cnt_q;

    // PC+4 wraps naturally at the word width; redirect targets drop their low two bits.
    assign pc_plus4    = pc_q + WORD_LEN'(PC_STEP);
    assign redirect_pc = {bus.branch_addr[WORD_LEN-1:2], 2'b00};

    // State register: every reset re-enters BOOT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: BOOT lasts one edge, RUN is sticky.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_BOOT: state_d = FETCH_RUN;
            FETCH_RUN:  state_d = FETCH_RUN;
            default:    state_d = FETCH_BOOT;
        endcase
    end

    // Per-edge actions; in RUN a redirect beats a freeze, which beats a normal fetch.
    always_comb begin
        pc_d       = pc_q;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        fetch_inc  = 1'b0;
        stall_inc  = 1'b0;
        case (state_q)
            FETCH_BOOT: begin
                ifid_flush = 1'b1;
            end
            FETCH_RUN: begin
                if (bus.branch_taken) begin
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                end else if (bus.freeze) begin
                    ifid_hold = 1'b1;
                    stall_inc = 1'b1;
                end else begin
                    pc_d      = pc_plus4;
                    fetch_inc = 1'b1;
                end
            end
            default: begin
                ifid_flush = 1'b1;
            end
        endcase
    end

    // Program counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Saturating performance counters: they stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fetch_inc && !(&fetch_cnt_q)) begin
                fetch_cnt_q <= fetch_cnt_q + CNT_LEN'(1);
            end
            if (stall_inc && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_LEN'(1);
            end
        end
    end

    if_id_reg #(
        .W (WORD_LEN)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .hold    (ifid_hold),
        .flush   (ifid_flush),
        .d_pc    (pc_plus4),
        .d_instr (bus.imem_instr),
        .q_pc    (bus.if_id_pc),
        .q_instr (bus.if_id_instr),
        .q_valid (bus.if_id_valid)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.fetch_count = fetch_cnt_q;
    assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed corner cases followed by randomized freeze/redirect traffic.
// The reference model tracks the architectural fetch rules per edge and queues the expected outputs.
// A separate monitor compares the DUT one time unit after each rising edge.
module tb_if_stage;

    logic clk;
    logic rst;

    if_stage_if #(.WORD_LEN(32), .CNT_LEN(32)) bus ();

    if_stage #(
        .WORD_LEN (32),
        .RESET_PC (32'h0),
        .CNT_LEN  (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        vld;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];

    int tests;
    int fails;

    // Reference model state.
    logic [31:0] m_pc;
    bit          m_boot;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;
    logic        m_vld;
    logic [31:0] m_fc;
    logic [31:0] m_sc;

    // Instruction memory contents: word at 0 is fixed, any address ending in 0x10 holds a NOP.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h8020000A;
        if (a[7:0] == 8'h10) return 32'h0;
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    always_comb bus.imem_instr = mem_word(bus.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_boot  = 1'b1;
        m_ipc   = 32'h0;
        m_instr = 32'h0;
        m_vld   = 1'b0;
        m_fc    = 32'h0;
        m_sc    = 32'h0;
    endtask

    // One clock edge of architectural behaviour.
    task automatic model_step(input logic f, input logic b, input logic [31:0] ba);
        if (m_boot) begin
            m_boot  = 1'b0;
            m_ipc   = 32'h0;
            m_instr = 32'h0;
            m_vld   = 1'b0;
        end else if (b) begin
            m_pc    = ba & 32'hFFFF_FFFC;
            m_ipc   = 32'h0;
            m_instr = 32'h0;
            m_vld   = 1'b0;
        end else if (f) begin
            if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        end else begin
            m_instr = mem_word(m_pc);
            m_pc    = m_pc + 32'd4;
            m_ipc   = m_pc;
            m_vld   = 1'b1;
            if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        end
    endtask

    // Drive inputs between edges, queue the expectation, then cross the next rising edge.
    task automatic cycle(input logic f, input logic b, input logic [31:0] ba);
        exp_t e;
        bus.freeze       = f;
        bus.branch_taken = b;
        bus.branch_addr  = ba;
        model_step(f, b, ba);
        e.pc    = m_pc;
        e.ipc   = m_ipc;
        e.instr = m_instr;
        e.vld   = m_vld;
        e.fc    = m_fc;
        e.sc    = m_sc;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},    bus.imem_addr,           32'h0);
        check({tag, "_ipc"},   bus.if_id_pc,            32'h0);
        check({tag, "_instr"}, bus.if_id_instr,         32'h0);
        check({tag, "_vld"},   {31'h0, bus.if_id_valid}, 32'h0);
        check({tag, "_fc"},    bus.fetch_count,         32'h0);
        check({tag, "_sc"},    bus.stall_count,         32'h0);
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic        f;
            logic        b;
            logic [31:0] ba;
            f  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 9) == 0);
            ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            cycle(f, b, ba);
        end
    endtask

    // Monitor: pop and compare one expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc",          bus.imem_addr,            e.pc);
                check("if_id_pc",    bus.if_id_pc,             e.ipc);
                check("if_id_instr", bus.if_id_instr,          e.instr);
                check("if_id_valid", {31'h0, bus.if_id_valid}, {31'h0, e.vld});
                check("fetch_count", bus.fetch_count,          e.fc);
                check("stall_count", bus.stall_count,          e.sc);
            end
        end
    end

    // Stimulus.
    initial begin
        tests = 0;
        fails = 0;
        rst              = 1'b1;
        bus.freeze       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_addr  = 32'h0;
        model_reset();
        #1 rst = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // BOOT edge, then ten straight-line fetches.
        cycle(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0);
        check("run10_pc", bus.imem_addr,   32'd40);
        check("run10_fc", bus.fetch_count, 32'd10);

        // Freeze three edges at pc=12, then release.
        cycle(1'b0, 1'b1, 32'd12);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
        check("frz_pc", bus.imem_addr,   32'd12);
        check("frz_sc", bus.stall_count, 32'd3);
        cycle(1'b0, 1'b0, 32'h0);
        check("frz_rel_pc", bus.imem_addr, 32'd16);

        // Redirect while frozen.
        cycle(1'b0, 1'b1, 32'hA0);
        cycle(1'b1, 1'b1, 32'h9C);
        check("br_frz_pc",  bus.imem_addr,            32'h9C);
        check("br_frz_vld", {31'h0, bus.if_id_valid}, 32'h0);

        // Misaligned target.
        cycle(1'b0, 1'b1, 32'h107);
        check("misalign_pc", bus.imem_addr, 32'h104);

        // PC wrap.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'h0);
        check("wrap_pc",  bus.imem_addr, 32'h0);
        check("wrap_ipc", bus.if_id_pc,  32'h0);

        random_cycles(300);

        // Asynchronous reset between edges.
        #1 rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        check("reboot_vld", {31'h0, bus.if_id_valid}, 32'h0);
        check("reboot_pc",  bus.imem_addr,            32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);
        random_cycles(200);

        @(posedge clk);
        #2;
        check("scoreboard_drain", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
